// File: rtl/photo_scan_ctrl.sv
// Goal-line phototransistor scanner: steps the ADC mux, tracks the darkest channel, debounces the goalie decision.
// Latency: one result per scan, NCH*(SETTLE*DIV+1)+1 cycles; results appear the cycle after COMMIT.
// Backpressure: none; free-running, results are held stable between scan_valid pulses.
//
// Ports:
//   CLK100MHZ     - sole clock, rising edge
//   reset         - asynchronous active-high reset, aborts any scan in progress
//   analog_input  - ADC sample for the channel currently on new_address
//   threshold     - darkness threshold, sampled in COMMIT
//   new_address   - ADC mux select
//   scan_valid    - one-cycle pulse when min_*/move_goalie update
//   min_address   - channel holding the minimum of the last completed scan
//   min_value     - minimum value of the last completed scan
//   move_goalie   - debounced "object detected" flag
//   output_goalie - processor word: [0]=move_goalie, [AW:1]=min_address, rest 0
module photo_scan_ctrl #(
    parameter int NCH    = 8,
    parameter int DW     = 8,
    parameter int DIV    = 500000,
    parameter int SETTLE = 4,
    parameter int HOLD   = 2,
    localparam int AW    = ($clog2(NCH) < 1) ? 1 : $clog2(NCH)
) (
    input  logic          CLK100MHZ,
    input  logic          reset,
    input  logic [DW-1:0] analog_input,
    input  logic [DW-1:0] threshold,
    output logic [AW-1:0] new_address,
    output logic          scan_valid,
    output logic [AW-1:0] min_address,
    output logic [DW-1:0] min_value,
    output logic          move_goalie,
    output logic [31:0]   output_goalie
);

    localparam int PW = ($clog2(DIV) < 1) ? 1 : $clog2(DIV);
    localparam int SW = ($clog2(SETTLE) < 1) ? 1 : $clog2(SETTLE);
    localparam int HW = $clog2(HOLD + 1);

    typedef enum logic [1:0] {
        ST_SETTLE  = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_COMMIT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [PW-1:0] presc;
    logic [SW-1:0] settle_cnt;
    logic [DW-1:0] run_min;
    logic [AW-1:0] run_addr;
    logic [HW-1:0] dbc;
    logic [HW-1:0] dbc_nxt;
    logic          tick;
    logic          settle_done;
    logic          last_ch;

    assign tick        = (presc == PW'(DIV - 1));
    assign settle_done = tick && (settle_cnt == SW'(SETTLE - 1));
    assign last_ch     = (new_address == AW'(NCH - 1));

    // State register
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state <= ST_SETTLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SETTLE:  if (settle_done) state_nxt = ST_CAPTURE;
            ST_CAPTURE: state_nxt = last_ch ? ST_COMMIT : ST_SETTLE;
            ST_COMMIT:  state_nxt = ST_SETTLE;
            default:    state_nxt = ST_SETTLE;
        endcase
    end

    // Debounce count after this scan: saturate at HOLD while dark, clear otherwise.
    always_comb begin
        dbc_nxt = '0;
        if (run_min < threshold) begin
            dbc_nxt = (dbc >= HW'(HOLD)) ? HW'(HOLD) : dbc + HW'(1);
        end
    end

    // Datapath
    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            presc       <= '0;
            settle_cnt  <= '0;
            run_min     <= '0;
            run_addr    <= '0;
            dbc         <= '0;
            new_address <= '0;
            scan_valid  <= 1'b0;
            min_address <= '0;
            min_value   <= '0;
            move_goalie <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            case (state)
                ST_SETTLE: begin
                    presc <= tick ? '0 : presc + PW'(1);
                    // Wrap past SETTLE-1 is harmless: CAPTURE clears it next.
                    if (tick) settle_cnt <= settle_cnt + SW'(1);
                end
                ST_CAPTURE: begin
                    presc      <= '0;
                    settle_cnt <= '0;
                    // Channel 0 seeds the search; strict less keeps the lowest index on ties.
                    if ((new_address == '0) || (analog_input < run_min)) begin
                        run_min  <= analog_input;
                        run_addr <= new_address;
                    end
                    new_address <= last_ch ? '0 : new_address + AW'(1);
                end
                ST_COMMIT: begin
                    presc       <= '0;
                    min_value   <= run_min;
                    min_address <= run_addr;
                    dbc         <= dbc_nxt;
                    move_goalie <= (dbc_nxt >= HW'(HOLD));
                    scan_valid  <= 1'b1;
                end
                default: begin
                    presc <= '0;
                end
            endcase
        end
    end

    always_comb begin
        output_goalie         = '0;
        output_goalie[0]      = move_goalie;
        output_goalie[AW:1]   = min_address;
    end

endmodule
